pin_entry_ctrl: RTL and testbench

//  Keypad-side front end for the lock checker. Collects BCD digits one key at a time and

---
 rtl/pin_entry_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_pin_entry_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pin_entry_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pin_entry_ctrl
// Brief    : Keypad front end for the lock checker. Assembles a 4-digit BCD
//            PIN, strobes enter, samples access/alarm, and drives the
//            unlocked/lockout status with consecutive-failure tracking.
// Revision : 1.0 - initial release
// ============================================================================
module pin_entry_ctrl #(
  parameter int unsigned ENTRY_TIMEOUT  = 1000,
  parameter int unsigned RESP_WAIT      = 2,
  parameter int unsigned UNLOCK_CYCLES  = 500,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 5000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        access,
  input  logic        alarm,
  output logic [15:0] inpin,
  output logic        enter,
  output logic [2:0]  digit_cnt,
  output logic        unlocked,
  output logic        lockout,
  output logic        key_err
);

  // Each timer only needs to reach PARAM-1; a 1-bit floor keeps PARAM=1 legal.
  localparam int IDLE_W = (ENTRY_TIMEOUT  > 1) ? $clog2(ENTRY_TIMEOUT)  : 1;
  localparam int RESP_W = (RESP_WAIT      > 1) ? $clog2(RESP_WAIT)      : 1;
  localparam int OPEN_W = (UNLOCK_CYCLES  > 1) ? $clog2(UNLOCK_CYCLES)  : 1;
  localparam int LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam int FAIL_W = $clog2(MAX_FAILS + 1);

  localparam logic [IDLE_W-1:0] c_idle_last = IDLE_W'(ENTRY_TIMEOUT - 1);
  localparam logic [RESP_W-1:0] c_resp_last = RESP_W'(RESP_WAIT - 1);
  localparam logic [OPEN_W-1:0] c_open_last = OPEN_W'(UNLOCK_CYCLES - 1);
  localparam logic [LOCK_W-1:0] c_lock_last = LOCK_W'(LOCKOUT_CYCLES - 1);
  localparam logic [FAIL_W-1:0] c_fail_last = FAIL_W'(MAX_FAILS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTRY = 3'd1,
    S_WAIT  = 3'd2,
    S_OPEN  = 3'd3,
    S_LOCK  = 3'd4
  } state_t;

  state_t             r_state;
  logic [15:0]        r_inpin;
  logic [2:0]         r_digit_cnt;
  logic               r_enter;
  logic               r_unlocked;
  logic               r_lockout;
  logic               r_key_err;
  logic [IDLE_W-1:0]  r_idle_cnt;
  logic [RESP_W-1:0]  r_resp_cnt;
  logic [OPEN_W-1:0]  r_open_cnt;
  logic [LOCK_W-1:0]  r_lock_cnt;
  logic [FAIL_W-1:0]  r_fail_cnt;

  logic w_digit;
  logic w_clear;
  logic w_submit;
  logic w_illegal;

  // Key classification, qualified by the strobe.
  assign w_digit   = key_valid && (key_code <= 4'd9);
  assign w_clear   = key_valid && (key_code == 4'hA);
  assign w_submit  = key_valid && (key_code == 4'hB);
  assign w_illegal = key_valid && (key_code >= 4'hC);

  // Entry/response/status state machine; all outputs registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_inpin     <= '0;
      r_digit_cnt <= '0;
      r_enter     <= 1'b0;
      r_unlocked  <= 1'b0;
      r_lockout   <= 1'b0;
      r_key_err   <= 1'b0;
      r_idle_cnt  <= '0;
      r_resp_cnt  <= '0;
      r_open_cnt  <= '0;
      r_lock_cnt  <= '0;
      r_fail_cnt  <= '0;
    end else begin
      r_enter   <= 1'b0;
      r_key_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_digit) begin
            r_inpin     <= {12'h000, key_code};
            r_digit_cnt <= 3'd1;
            r_idle_cnt  <= '0;
            r_state     <= S_ENTRY;
          end else if (w_illegal) begin
            r_key_err <= 1'b1;
          end
        end
        S_ENTRY: begin
          if (key_valid) begin
            // Any key restarts the idle timer, including one on the expiry cycle.
            r_idle_cnt <= '0;
            if (w_digit) begin
              if (r_digit_cnt < 3'd4) begin
                r_inpin     <= {r_inpin[11:0], key_code};
                r_digit_cnt <= r_digit_cnt + 3'd1;
              end else begin
                r_key_err <= 1'b1;
              end
            end else if (w_submit) begin
              if (r_digit_cnt == 3'd4) begin
                r_enter    <= 1'b1;
                r_resp_cnt <= '0;
                r_state    <= S_WAIT;
              end else begin
                r_key_err <= 1'b1;
              end
            end else if (w_clear) begin
              r_inpin     <= '0;
              r_digit_cnt <= '0;
              r_state     <= S_IDLE;
            end else begin
              r_key_err <= 1'b1;
            end
          end else if (r_idle_cnt == c_idle_last) begin
            r_inpin     <= '0;
            r_digit_cnt <= '0;
            r_state     <= S_IDLE;
          end else begin
            r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
          end
        end
        S_WAIT: begin
          if (r_resp_cnt == c_resp_last) begin
            if (access) begin
              r_fail_cnt <= '0;
              r_unlocked <= 1'b1;
              r_open_cnt <= '0;
              r_state    <= S_OPEN;
            end else if (alarm || (r_fail_cnt == c_fail_last)) begin
              r_lockout   <= 1'b1;
              r_inpin     <= '0;
              r_digit_cnt <= '0;
              r_lock_cnt  <= '0;
              r_state     <= S_LOCK;
            end else begin
              r_fail_cnt  <= r_fail_cnt + FAIL_W'(1);
              r_inpin     <= '0;
              r_digit_cnt <= '0;
              r_state     <= S_IDLE;
            end
          end else begin
            r_resp_cnt <= r_resp_cnt + RESP_W'(1);
          end
        end
        S_OPEN: begin
          if (w_clear || (r_open_cnt == c_open_last)) begin
            r_unlocked  <= 1'b0;
            r_inpin     <= '0;
            r_digit_cnt <= '0;
            r_state     <= S_IDLE;
          end else begin
            r_open_cnt <= r_open_cnt + OPEN_W'(1);
          end
        end
        S_LOCK: begin
          if (r_lock_cnt == c_lock_last) begin
            r_lockout  <= 1'b0;
            r_fail_cnt <= '0;
            r_state    <= S_IDLE;
          end else begin
            r_lock_cnt <= r_lock_cnt + LOCK_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign inpin     = r_inpin;
  assign enter     = r_enter;
  assign digit_cnt = r_digit_cnt;
  assign unlocked  = r_unlocked;
  assign lockout   = r_lockout;
  assign key_err   = r_key_err;

endmodule
`default_nettype wire

// File: tb/tb_pin_entry_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pin_entry_ctrl
// Brief    : Directed self-checking bench for pin_entry_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pin_entry_ctrl;

  localparam int unsigned c_timeout = 20;
  localparam int unsigned c_resp    = 2;
  localparam int unsigned c_unlock  = 10;
  localparam int unsigned c_fails   = 3;
  localparam int unsigned c_lockcyc = 30;

  logic        clk;
  logic        reset;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        access;
  logic        alarm;
  logic [15:0] inpin;
  logic        enter;
  logic [2:0]  digit_cnt;
  logic        unlocked;
  logic        lockout;
  logic        key_err;

  int n_total = 0;
  int n_bad   = 0;

  pin_entry_ctrl #(
    .ENTRY_TIMEOUT  (c_timeout),
    .RESP_WAIT      (c_resp),
    .UNLOCK_CYCLES  (c_unlock),
    .MAX_FAILS      (c_fails),
    .LOCKOUT_CYCLES (c_lockcyc)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .key_valid (key_valid),
    .key_code  (key_code),
    .access    (access),
    .alarm     (alarm),
    .inpin     (inpin),
    .enter     (enter),
    .digit_cnt (digit_cnt),
    .unlocked  (unlocked),
    .lockout   (lockout),
    .key_err   (key_err)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #1ms;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] code);
    key_valid = 1'b1;
    key_code  = code;
    step();
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  // Full attempt 1-2-3-4-SUBMIT; returns just after the response is sampled.
  task automatic attempt(input logic acc, input logic alm);
    access = acc;
    alarm  = alm;
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'hB);
    for (int i = 0; i < int'(c_resp); i++) step();
    access = 1'b0;
    alarm  = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int hi_cnt;

  initial begin
    reset = 1'b0; key_valid = 1'b0; key_code = 4'h0; access = 1'b0; alarm = 1'b0;
    wait_cycles(3);
    chk("rst_inpin", 32'(inpin), 32'h0);
    chk("rst_enter", 32'(enter), 32'h0);
    chk("rst_cnt", 32'(digit_cnt), 32'h0);
    chk("rst_unl", 32'(unlocked), 32'h0);
    chk("rst_lock", 32'(lockout), 32'h0);
    chk("rst_kerr", 32'(key_err), 32'h0);
    reset = 1'b1;
    step();

    // 1: granted attempt
    access = 1'b1;
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    chk("t1_inpin", 32'(inpin), 32'h1234);
    chk("t1_cnt4", 32'(digit_cnt), 32'd4);
    press(4'hB);
    chk("t1_enter", 32'(enter), 32'h1);
    step();
    chk("t1_enter_off", 32'(enter), 32'h0);
    chk("t1_unl_early", 32'(unlocked), 32'h0);
    step();
    access = 1'b0;
    hi_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (unlocked) hi_cnt++;
      step();
    end
    chk("t1_unl_len", 32'(hi_cnt), 32'(c_unlock));
    chk("t1_inpin_clr", 32'(inpin), 32'h0);

    // 2: short submit, overflow digit, illegal/idle keys
    press(4'd1); press(4'd2); press(4'hB);
    chk("t2_kerr_sub", 32'(key_err), 32'h1);
    chk("t2_noenter", 32'(enter), 32'h0);
    chk("t2_cnt2", 32'(digit_cnt), 32'd2);
    press(4'd3);
    chk("t2_kerr_off", 32'(key_err), 32'h0);
    press(4'd4); press(4'd5);
    chk("t2_kerr_5", 32'(key_err), 32'h1);
    chk("t2_inpin", 32'(inpin), 32'h1234);
    press(4'hA);
    chk("t2_clr_cnt", 32'(digit_cnt), 32'd0);
    chk("t2_clr_pin", 32'(inpin), 32'h0);
    press(4'hC);
    chk("t2_idle_ill", 32'(key_err), 32'h1);
    press(4'hA);
    chk("t2_idle_clr", 32'(key_err), 32'h0);

    // 3: three rejects -> lockout, keys ignored, fail counter cleared after
    attempt(1'b0, 1'b0);
    chk("t3_rej1", 32'(lockout), 32'h0);
    chk("t3_rej1_pin", 32'(inpin), 32'h0);
    attempt(1'b0, 1'b0);
    chk("t3_rej2", 32'(lockout), 32'h0);
    attempt(1'b0, 1'b0);
    chk("t3_rej3", 32'(lockout), 32'h1);
    hi_cnt = 1;
    press(4'd5);
    if (lockout) hi_cnt++;
    chk("t3_lock_key", 32'(digit_cnt), 32'd0);
    press(4'hC);
    if (lockout) hi_cnt++;
    chk("t3_lock_ill", 32'(key_err), 32'h0);
    for (int i = 0; i < 40; i++) begin
      step();
      if (lockout) hi_cnt++;
    end
    chk("t3_lock_len", 32'(hi_cnt), 32'(c_lockcyc));
    attempt(1'b0, 1'b0);
    chk("t3_fail_clr", 32'(lockout), 32'h0);

    // 4: alarm forces lockout; grant resets the fail counter; access beats alarm
    attempt(1'b0, 1'b1);
    chk("t4_alarm", 32'(lockout), 32'h1);
    wait_cycles(35);
    chk("t4_alarm_end", 32'(lockout), 32'h0);
    attempt(1'b0, 1'b0);
    attempt(1'b0, 1'b0);
    chk("t4_rej2", 32'(lockout), 32'h0);
    attempt(1'b1, 1'b1);
    chk("t4_grant", 32'(unlocked), 32'h1);
    chk("t4_grant_nolk", 32'(lockout), 32'h0);
    press(4'hA);
    chk("t4_open_clr", 32'(unlocked), 32'h0);
    attempt(1'b0, 1'b0);
    attempt(1'b0, 1'b0);
    chk("t4_post_grant", 32'(lockout), 32'h0);
    attempt(1'b0, 1'b0);
    chk("t4_third", 32'(lockout), 32'h1);
    wait_cycles(35);

    // 5: entry timeout, and a key on the expiry cycle
    press(4'd9); press(4'd8);
    wait_cycles(int'(c_timeout) - 1);
    chk("t5_before_to", 32'(inpin), 32'h0098);
    step();
    chk("t5_to_pin", 32'(inpin), 32'h0);
    chk("t5_to_cnt", 32'(digit_cnt), 32'd0);
    press(4'd9); press(4'd8);
    wait_cycles(int'(c_timeout) - 1);
    press(4'd7);
    chk("t5_key_wins", 32'(inpin), 32'h0987);
    chk("t5_key_cnt", 32'(digit_cnt), 32'd3);
    press(4'hA);

    // 6: asynchronous reset in WAIT and in LOCK
    attempt(1'b0, 1'b0);
    attempt(1'b0, 1'b0);
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'hB);
    chk("t6_wait_enter", 32'(enter), 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("t6_wait_outs", 32'({inpin, enter, digit_cnt, unlocked, lockout, key_err}), 32'h0);
    @(posedge clk); #1 reset = 1'b1;
    attempt(1'b0, 1'b0);
    chk("t6_fail_clr1", 32'(lockout), 32'h0);
    attempt(1'b0, 1'b0);
    attempt(1'b0, 1'b0);
    chk("t6_in_lock", 32'(lockout), 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("t6_lock_outs", 32'({inpin, enter, digit_cnt, unlocked, lockout, key_err}), 32'h0);
    @(posedge clk); #1 reset = 1'b1;
    attempt(1'b0, 1'b0);
    chk("t6_fail_clr2", 32'(lockout), 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
